user_wb_gpio: RTL and testbench
===============================

# user_wb_gpio

Wishbone B4 classic responder for the user area, answering management-SoC transactions on the user project's `wbs_*` slave port. Exposes a register bank that drives 24 user I/O pads (pads 5..28) as software-controlled GPIO, samples their inputs through a synchronizer, and raises a maskable rising-edge interrupt on `user_irq[0]`. Instantiated inside `user_project_wrapper` alongside the user design.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: decoded window base; compared on bits [31:8].
- `NPINS`, default 24: number of GPIO pins, legal range 1..32.

- `wb_clk_i`  in  1  sole clock; all flops rise-edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`  in  1  strobe.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_we_i`  in  1  1 = write.
- `wbs_sel_i`  in  4  byte-lane enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid only while ack=1, else 0.
- `io_in`  in  NPINS  pad inputs, asynchronous.
- `io_out`  out  NPINS  pad output values.
- `io_oeb`  out  NPINS  pad output-enable, active low.
- `irq`  out  3  interrupt lines to `user_irq`.

## Operation
- Request = `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8])`. Non-matching requests: no ack, no state change.
- Register select `wbs_adr_i[4:2]`; bits [1:0] ignored.
  - 0 DATA_OUT rw, reset 0, drives `io_out`.
  - 1 OEB rw, reset all ones (all pins inputs), drives `io_oeb`.
  - 2 DATA_IN ro, synchronized pad inputs.
  - 3 IRQ_EN rw, reset 0, per-pin rising-edge enable.
  - 4 IRQ_STAT rw1c, reset 0, per-pin latched edge flag.
  - 5 ID ro, constant 32'h4750_494F.
  - 6,7 read 0, writes ignored but acked.
- Writes honor `wbs_sel_i` per byte. Bits at or above NPINS read 0 and are not stored.
- Input path: 2-flop synchronizer s1→s2, plus s3 = previous s2. edge[i] = s2[i] & ~s3[i]. All reset to 0.
- IRQ_STAT[i] sets when edge[i] & IRQ_EN[i]. A W1C bit clears only with no coincident set; a set in the same cycle as a W1C write wins.
- `irq[0]` registered = |(IRQ_STAT & IRQ_EN). `irq[2:1]` tied 0. Clearing IRQ_EN masks `irq[0]` without clearing IRQ_STAT.

## Timing
- Ack FSM, IDLE/ACK:
  - IDLE→ACK on request.
  - ACK→IDLE unconditionally.
  - `wbs_ack_o` = 1 exactly in ACK. Each transaction has one wait state. A strobe held through ACK starts a new transaction on the next cycle, so the ack pattern is 1,0,1,0.
- Write state updates on the edge entering ACK, so `io_out`/`io_oeb` change on the same edge `wbs_ack_o` rises.
- Read data is registered on the edge entering ACK, from the current register values.
- Pad edge before clock k: DATA_IN readable after edge k+1; IRQ_STAT sets at k+2; `irq[0]` rises at k+3.
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `io_out`=0, `io_oeb`=all ones, `irq`=0, FSM=IDLE.
- Reset asserted mid-transaction: the ack is dropped next cycle, any pending write is discarded, and the master must restart.
- `wbs_cyc_i` dropping while in ACK has no effect; ack still completes.

## Test plan
- Reset then reads: OEB=32'h00FF_FFFF, DATA_OUT=0, ID=32'h4750_494F. Every read acks exactly one cycle after strobe, and `wbs_dat_o` is 0 outside ack.
- Write DATA_OUT=32'hDEAD_BEEF with sel=4'b0101, after DATA_OUT=0 -> `io_out`=24'hAD00EF on the ack edge. Readback = 32'h00AD_00EF.
- Drive `io_in`=24'h000001 with IRQ_EN=1 -> DATA_IN reads 1. `irq[0]` rises exactly 3 clocks after the first sampling edge. Writing IRQ_STAT=1 clears it, and `irq[0]` drops the next cycle.
- Second rising edge on pin 0 timed so the set coincides with the W1C write -> IRQ_STAT stays 1 and `irq[0]` stays high.
- Strobe with `wbs_adr_i`=32'h3000_0100 (outside window) held 4 cycles -> no ack and no register change. Held in-window strobe -> ack pattern 1,0,1,0.
- Assert `wb_rst_i` in the cycle a write to OEB enters ACK -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/user_wb_gpio.sv
// Wishbone classic GPIO responder for the user area: output/enable/input registers,
// a pad-input synchronizer, and a maskable rising-edge interrupt on irq[0].
`timescale 1ns/1ps
module user_wb_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NPINS     = 24
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    output logic [2:0]       irq
);
    // Handshake: a request (cyc & stb & window hit) seen in IDLE is accepted on
    // the next rising edge, which moves to ACK for exactly one cycle; ACK always
    // returns to IDLE, so a held strobe gives ack 1,0,1,0.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [31:0] ID_VALUE = 32'h4750_494F;

    state_t           state;
    state_t           state_next;
    logic             req;
    logic             accept;
    logic             wr_strobe;
    logic             rd_strobe;
    logic [2:0]       reg_sel;
    logic [31:0]      byte_mask;
    logic [NPINS-1:0] data_out;
    logic [NPINS-1:0] oeb;
    logic [NPINS-1:0] irq_en;
    logic [NPINS-1:0] irq_stat;
    logic [NPINS-1:0] stat_clr;
    logic [NPINS-1:0] stat_next;
    logic [NPINS-1:0] sync1;
    logic [NPINS-1:0] sync2;
    logic [NPINS-1:0] sync3;
    logic [NPINS-1:0] pin_rise;
    logic [31:0]      rd_mux;
    logic [31:0]      rd_data;
    logic             irq0;
    logic             unused_adr;

    function automatic logic [NPINS-1:0] merge(input logic [NPINS-1:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [31:0] wmask);
        logic [NPINS-1:0] res;
        for (int i = 0; i < NPINS; i++) begin
            res[i] = wmask[i] ? wdat[i] : cur[i];
        end
        return res;
    endfunction

    function automatic logic [31:0] widen(input logic [NPINS-1:0] v);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < NPINS; i++) begin
            res[i] = v[i];
        end
        return res;
    endfunction

    assign req        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_sel    = wbs_adr_i[4:2];
    assign byte_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                         {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign accept     = (state == IDLE) & req;
    assign wr_strobe  = accept & wbs_we_i;
    assign rd_strobe  = accept & ~wbs_we_i;
    assign unused_adr = &{1'b0, wbs_adr_i[7:5], wbs_adr_i[1:0]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            3'd0:    rd_mux = widen(data_out);
            3'd1:    rd_mux = widen(oeb);
            3'd2:    rd_mux = widen(sync2);
            3'd3:    rd_mux = widen(irq_en);
            3'd4:    rd_mux = widen(irq_stat);
            3'd5:    rd_mux = ID_VALUE;
            default: rd_mux = '0;
        endcase
    end

    // A new edge in the same cycle as a W1C write must survive, so set is OR-ed last.
    always_comb begin
        stat_clr = '0;
        if (wr_strobe && reg_sel == 3'd4) begin
            for (int i = 0; i < NPINS; i++) begin
                stat_clr[i] = wbs_dat_i[i] & byte_mask[i];
            end
        end
    end

    assign pin_rise  = sync2 & ~sync3;
    assign stat_next = (irq_stat & ~stat_clr) | (pin_rise & irq_en);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            data_out <= '0;
            oeb      <= '1;
            irq_en   <= '0;
            irq_stat <= '0;
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            rd_data  <= '0;
            irq0     <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_strobe) begin
                case (reg_sel)
                    3'd0:    data_out <= merge(data_out, wbs_dat_i, byte_mask);
                    3'd1:    oeb      <= merge(oeb, wbs_dat_i, byte_mask);
                    3'd3:    irq_en   <= merge(irq_en, wbs_dat_i, byte_mask);
                    default: ;
                endcase
            end
            irq_stat <= stat_next;
            sync1    <= io_in;
            sync2    <= sync1;
            sync3    <= sync2;
            // Cleared whenever not loading, so read data is zero outside the ack cycle.
            rd_data  <= rd_strobe ? rd_mux : '0;
            irq0     <= |(irq_stat & irq_en);
        end
    end

    assign wbs_ack_o = (state == ACK);
    assign wbs_dat_o = rd_data;
    assign io_out    = data_out;
    assign io_oeb    = oeb;
    assign irq       = {2'b00, irq0};

endmodule

// File: tb/tb_user_wb_gpio.sv
// Directed bench for user_wb_gpio: a register-access vector table plus hand-written
// sequences for output timing, interrupt latency, W1C/set collision, windowing and reset.
`timescale 1ns/1ps
module tb_user_wb_gpio;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ID   = 32'h4750_494F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [23:0] io_in = '0;
    logic [23:0] io_out;
    logic [23:0] io_oeb;
    logic [2:0]  irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    user_wb_gpio #(.BASE_ADDR(BASE), .NPINS(24)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the FSM idle; returns #1 after the ack edge.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack && lat < 8);
        rd  = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_idle(input string name);
        tick();
        check({name, "_ack_low"}, {31'b0, ack}, 32'h0);
        check({name, "_dat_zero"}, dat_o, 32'h0);
    endtask

    task automatic wb_access(input string name, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             input logic do_chk, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(w, a, s, d, rd, lat);
        check({name, "_lat"}, lat, 32'd1);
        if (do_chk) check({name, "_rd"}, rd, exp);
        wb_idle(name);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;

        vecs[0]  = '{1'b0, BASE + 32'h04, 4'hF, 32'h0,         32'h00FF_FFFF};
        vecs[1]  = '{1'b0, BASE + 32'h00, 4'hF, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, BASE + 32'h14, 4'hF, 32'h0,         ID};
        vecs[3]  = '{1'b1, BASE + 32'h00, 4'b0101, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b0, BASE + 32'h00, 4'hF, 32'h0,         32'h00AD_00EF};
        vecs[5]  = '{1'b1, BASE + 32'h04, 4'hF, 32'hFFFF_FF00, 32'h0};
        vecs[6]  = '{1'b0, BASE + 32'h04, 4'hF, 32'h0,         32'h00FF_FF00};
        vecs[7]  = '{1'b1, BASE + 32'h04, 4'b1000, 32'hFF00_0000, 32'h0};
        vecs[8]  = '{1'b0, BASE + 32'h04, 4'hF, 32'h0,         32'h00FF_FF00};
        vecs[9]  = '{1'b1, BASE + 32'h18, 4'hF, 32'h1234_5678, 32'h0};
        vecs[10] = '{1'b0, BASE + 32'h18, 4'hF, 32'h0,         32'h0};
        vecs[11] = '{1'b0, BASE + 32'h1C, 4'hF, 32'h0,         32'h0};
        vecs[12] = '{1'b0, BASE + 32'h17, 4'hF, 32'h0,         ID};
        vecs[13] = '{1'b0, BASE + 32'h20, 4'hF, 32'h0,         32'h00AD_00EF};
        vecs[14] = '{1'b0, BASE + 32'h08, 4'hF, 32'h0,         32'h0};
        vecs[15] = '{1'b0, BASE + 32'h10, 4'hF, 32'h0,         32'h0};
        vecs[16] = '{1'b0, BASE + 32'h0C, 4'hF, 32'h0,         32'h0};

        // Reset state
        repeat (3) tick();
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_io_out", {8'h0, io_out}, 32'h0);
        check("rst_io_oeb", {8'h0, io_oeb}, 32'h00FF_FFFF);
        check("rst_irq", {29'b0, irq}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            wb_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel,
                      vecs[i].dat, !vecs[i].we, vecs[i].exp);
        end
        check("oeb_after_table", {8'h0, io_oeb}, 32'h00FF_FF00);

        // io_out changes on the same edge ack rises
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; dat = 32'h0012_3456;
        check("io_out_before_ack", {8'h0, io_out}, 32'h00AD_00EF);
        tick();
        check("io_out_ack_edge_ack", {31'b0, ack}, 32'h1);
        check("io_out_ack_edge", {8'h0, io_out}, 32'h0012_3456);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_idle("io_out_wr");

        // Interrupt latency: pad edge before clock k, irq[0] after k+3
        wb_access("en_wr", 1'b1, BASE + 32'h0C, 4'hF, 32'h1, 1'b0, 32'h0);
        io_in = 24'h00_0001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("irq_lat_c%0d", c), {29'b0, irq}, (c == 4) ? 32'h1 : 32'h0);
        end
        wb_access("din_rd", 1'b0, BASE + 32'h08, 4'hF, 32'h0, 1'b1, 32'h1);
        wb_access("stat_rd1", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 32'h1);
        wb_xfer(1'b1, BASE + 32'h10, 4'hF, 32'h1, rd, lat);
        check("w1c_lat", lat, 32'd1);
        check("w1c_irq_still_high", {29'b0, irq}, 32'h1);
        tick();
        check("w1c_irq_dropped", {29'b0, irq}, 32'h0);
        wb_access("stat_rd2", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 32'h0);

        // Second edge timed so the set lands on the W1C write edge
        io_in = 24'h0;
        repeat (4) tick();
        io_in = 24'h00_0001;
        tick();
        tick();
        wb_xfer(1'b1, BASE + 32'h10, 4'hF, 32'h1, rd, lat);
        check("coll_lat", lat, 32'd1);
        tick();
        check("coll_irq_high", {29'b0, irq}, 32'h1);
        wb_access("coll_stat", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 32'h1);
        check("coll_irq_held", {29'b0, irq}, 32'h1);

        // Clearing the enable masks irq[0] but keeps the status
        wb_access("en_clr", 1'b1, BASE + 32'h0C, 4'hF, 32'h0, 1'b0, 32'h0);
        check("mask_irq_low", {29'b0, irq}, 32'h0);
        wb_access("mask_stat", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 32'h1);

        // Out-of-window strobe held four cycles
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; sel = 4'hF; dat = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("oow_ack_c%0d", c), {31'b0, ack}, 32'h0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("oow_io_out", {8'h0, io_out}, 32'h0012_3456);
        check("oow_io_oeb", {8'h0, io_oeb}, 32'h00FF_FF00);
        wb_access("oow_rd", 1'b0, BASE, 4'hF, 32'h0, 1'b1, 32'h0012_3456);

        // Held in-window strobe gives ack 1,0,1,0
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h14; sel = 4'hF;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("held_ack_c%0d", c), {31'b0, ack}, (c % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("held_dat_c%0d", c), dat_o, (c % 2 == 0) ? ID : 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        wb_idle("held");

        // Reset asserted while a write to OEB sits in ACK
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; sel = 4'hF; dat = 32'h0;
        tick();
        check("rstmid_ack", {31'b0, ack}, 32'h1);
        check("rstmid_oeb_written", {8'h0, io_oeb}, 32'h0);
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("rstmid_ack_drop", {31'b0, ack}, 32'h0);
        check("rstmid_oeb", {8'h0, io_oeb}, 32'h00FF_FFFF);
        check("rstmid_io_out", {8'h0, io_out}, 32'h0);
        check("rstmid_dat", dat_o, 32'h0);
        check("rstmid_irq", {29'b0, irq}, 32'h0);
        rst = 1'b0;
        tick();
        wb_access("post_rst_oeb", 1'b0, BASE + 32'h04, 4'hF, 32'h0, 1'b1, 32'h00FF_FFFF);
        wb_access("post_rst_stat", 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
